double_to_float: RTL
====================

// Module: double_to_float
// PURPOSE
//  Converts an IEEE-754 binary64 value to binary32 with round-to-nearest-even.
//  Sits downstream of double_multiplier; consumes its output_z/stb/ack stream and
//  feeds single-precision consumers. One conversion in flight; multi-cycle FSM.
// PARAMETERS
//  None. Widths are fixed at 64 in and 32 out. State encodings are local constants.
// PORTS
//  clk           in   1   clock; all logic on posedge
//  rst           in   1   reset, synchronous, active-high
//  input_a       in   64  binary64 operand
//  input_a_stb   in   1   operand valid
//  input_a_ack   out  1   block ready; transfer when input_a_stb && input_a_ack on a clk edge
//  output_z      out  32  binary32 result
//  output_z_stb  out  1   result valid
//  output_z_ack  in   1   consumer ready; transfer when output_z_stb && output_z_ack on an edge
//  output_z_flags out 4   {invalid,overflow,underflow,inexact}; present only with DOUBLE_TO_FLOAT_FLAGS_EN
// BEHAVIOUR
//  Reset: state=get_a; input_a_ack=0; output_z_stb=0; output_z=0; flags=0. rst overrides every
//   state, including mid-conversion and during put_z. The in-flight result is discarded.
//  Handshake: ack and stb are registered. get_a sets input_a_ack=1 and clears it on the transfer edge.
//   put_z sets output_z_stb=1 and loads output_z. Both stay stable until the transfer edge.
//   On that edge stb drops and the FSM returns to get_a. input_a_ack is never high while output_z_stb is high.
//  FSM: get_a -> unpack -> special_cases -> {put_z | denormalise} -> round -> pack -> put_z -> get_a.
//  unpack: s=a[63]; e=a[62:52]-1023 (signed 12b); m53={1,a[51:0]}.
//   z_m=m53[52:29] (24b); guard=m53[28]; round_bit=m53[27]; sticky=|m53[26:0].
//  special_cases: checked in this priority order.
//   1) NaN (exp=2047, frac!=0): z={s,8'hFF,1'b1,22'b0}.
//   2) Inf (exp=2047): z={s,8'hFF,23'b0}.
//   3) exp=0 (zero or binary64 subnormal, < 2^-1022): z={s,31'b0}.
//   4) e>127: z={s,8'hFF,23'b0}.
//   5) e<=-151: z={s,31'b0}.
//   Cases 1-5 go straight to put_z. Otherwise go to denormalise.
//  denormalise: while e<-126, do one shift per cycle:
//   z_m>>=1; guard<=z_m[0]; round_bit<=guard; sticky<=sticky|round_bit; e+=1.
//   Between 0 and 24 cycles. Then go to round.
//  round (RNE): if guard&&(round_bit|sticky|z_m[0]) then z_m+=1.
//   On carry out (z_m was 24'hFFFFFF): z_m=24'h800000 and e+=1.
//  pack: z={s,e+127,z_m[22:0]}. If e==-126 && z_m[23]==0, the exp field is 0 (subnormal;
//   rounding up into 0x800000 yields exp field 1). If e>127 after rounding: z={s,8'hFF,23'b0}.
//  Latency from the input transfer edge to output_z_stb high:
//   normal path: 6 cycles + one per denormalise shift.
//   special_cases exit: 3 cycles.
//  Back-to-back: a new input is accepted no earlier than 1 cycle after the output transfer edge.
// CONFIGURATION
//  DOUBLE_TO_FLOAT_FLAGS_EN defined: output_z_flags is driven, registered, and valid with output_z_stb.
//   invalid   = NaN input.
//   overflow  = finite input that produced Inf.
//   underflow = result is tiny (subnormal or zero from nonzero input) and inexact.
//   inexact   = any of guard/round/sticky set, or any overflow/underflow to zero.
//   Zero/Inf inputs raise no flags.
//  Not defined: the port and all flag logic are absent. Data results are identical in both builds.
// TESTING
//  1. Normal path: in 0x3FF0000000000000 -> 0x3F800000, stb high exactly 6 cycles after the input transfer.
//     In 0x400921FB54442D18 -> 0x40490FDB (rounds up, inexact).
//  2. Overflow: 0x47EFFFFFE0000000 -> 0x7F7FFFFF.
//     0x47EFFFFFF0000000 (tie, odd) -> 0x7F800000 (overflow, inexact).
//     0xC7F0000000000000 -> 0xFF800000.
//  3. Subnormal output: 0x36A0000000000000 -> 0x00000001.
//     0x3690000000000000 (tie) -> 0x00000000.
//     0x3698000000000000 -> 0x00000001.
//     0x380FFFFFF0000000 -> 0x00800000 (round carries into normal).
//  4. Specials: 0x7FF0000000000001 -> 0x7FC00000 (invalid).
//     0xFFF0000000000000 -> 0xFF800000.
//     0x8000000000000000 -> 0x80000000.
//     0x0000000000000001 -> 0x00000000. Each returns 3 cycles after the input transfer.
//  5. Backpressure: hold output_z_ack=0 for 10 cycles -> stb and output_z stable, input_a_ack stays 0.
//     Chain with double_multiplier: 1.5*2.0 -> 0x40400000.
//  6. Reset: assert rst for 1 cycle during denormalise and again during put_z ->
//     next cycle stb=0, ack=0, state get_a. The next input converts correctly.

Source files
------------

// File: rtl/double_to_float_if.sv
// Operand/result stream bundle for double_to_float; slave is the converter's view.
// output_z_flags exists only when DOUBLE_TO_FLOAT_FLAGS_EN is defined.
interface double_to_float_if;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
    logic [3:0]  output_z_flags;

    modport master (output input_a, input_a_stb, output_z_ack,
                    input  input_a_ack, output_z, output_z_stb, output_z_flags);
    modport slave  (input  input_a, input_a_stb, output_z_ack,
                    output input_a_ack, output_z, output_z_stb, output_z_flags);
`else
    modport master (output input_a, input_a_stb, output_z_ack,
                    input  input_a_ack, output_z, output_z_stb);
    modport slave  (input  input_a, input_a_stb, output_z_ack,
                    output input_a_ack, output_z, output_z_stb);
`endif
endinterface

// File: rtl/double_to_float.sv
// binary64 -> binary32 converter, round-to-nearest-even, one conversion in flight.
// Latency 6 cycles + 1 per denormalise shift (3 for specials); output held until output_z_ack.
// DOUBLE_TO_FLOAT_FLAGS_EN adds registered {invalid,overflow,underflow,inexact} flags.
module double_to_float (
    input  logic              clk,
    input  logic              rst,
    double_to_float_if.slave  io
);

    typedef enum logic [2:0] {
        GET_A, UNPACK, SPECIAL_CASES, DENORMALISE, ROUND, PACK, PUT_Z
    } state_t;

    state_t             state, state_nxt;
    logic [63:0]        a, a_nxt;
    logic               s, s_nxt;
    logic signed [11:0] e, e_nxt;
    logic [23:0]        z_m, z_m_nxt;
    logic               guard, guard_nxt;
    logic               round_bit, round_bit_nxt;
    logic               sticky, sticky_nxt;
    logic [31:0]        z, z_nxt;
    logic               ack_q, ack_nxt;
    logic               stb_q, stb_nxt;
    logic [31:0]        out_q, out_nxt;
    logic [7:0]         exp8;
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
    logic [3:0]         flg, flg_nxt;
    logic [3:0]         flags_q, flags_nxt;
    logic               inexact_q, inexact_nxt;
`endif

    assign io.input_a_ack  = ack_q;
    assign io.output_z_stb = stb_q;
    assign io.output_z     = out_q;
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
    assign io.output_z_flags = flags_q;
`endif

    // Low byte of the bias addition is all the exp field needs.
    assign exp8 = e[7:0] + 8'd127;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GET_A;
            a         <= '0;
            s         <= 1'b0;
            e         <= '0;
            z_m       <= '0;
            guard     <= 1'b0;
            round_bit <= 1'b0;
            sticky    <= 1'b0;
            z         <= '0;
            ack_q     <= 1'b0;
            stb_q     <= 1'b0;
            out_q     <= '0;
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
            flg       <= '0;
            flags_q   <= '0;
            inexact_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            a         <= a_nxt;
            s         <= s_nxt;
            e         <= e_nxt;
            z_m       <= z_m_nxt;
            guard     <= guard_nxt;
            round_bit <= round_bit_nxt;
            sticky    <= sticky_nxt;
            z         <= z_nxt;
            ack_q     <= ack_nxt;
            stb_q     <= stb_nxt;
            out_q     <= out_nxt;
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
            flg       <= flg_nxt;
            flags_q   <= flags_nxt;
            inexact_q <= inexact_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        a_nxt         = a;
        s_nxt         = s;
        e_nxt         = e;
        z_m_nxt       = z_m;
        guard_nxt     = guard;
        round_bit_nxt = round_bit;
        sticky_nxt    = sticky;
        z_nxt         = z;
        ack_nxt       = ack_q;
        stb_nxt       = stb_q;
        out_nxt       = out_q;
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
        flg_nxt       = flg;
        flags_nxt     = flags_q;
        inexact_nxt   = inexact_q;
`endif
        case (state)
            GET_A: begin
                ack_nxt = 1'b1;
                if (ack_q && io.input_a_stb) begin
                    a_nxt     = io.input_a;
                    ack_nxt   = 1'b0;
                    state_nxt = UNPACK;
                end
            end
            UNPACK: begin
                s_nxt         = a[63];
                e_nxt         = $signed({1'b0, a[62:52]}) - 12'sd1023;
                z_m_nxt       = {1'b1, a[51:29]};
                guard_nxt     = a[28];
                round_bit_nxt = a[27];
                sticky_nxt    = |a[26:0];
                state_nxt     = SPECIAL_CASES;
            end
            SPECIAL_CASES: begin
                state_nxt = PUT_Z;
                if (a[62:52] == 11'h7FF && a[51:0] != '0) begin
                    z_nxt = {s, 8'hFF, 1'b1, 22'b0};
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                    flg_nxt = 4'b1000;
`endif
                end else if (a[62:52] == 11'h7FF) begin
                    z_nxt = {s, 8'hFF, 23'b0};
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                    flg_nxt = 4'b0000;
`endif
                end else if (a[62:52] == 11'h000) begin
                    z_nxt = {s, 31'b0};
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                    flg_nxt = (a[51:0] != '0) ? 4'b0011 : 4'b0000;
`endif
                end else if (e > 12'sd127) begin
                    z_nxt = {s, 8'hFF, 23'b0};
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                    flg_nxt = 4'b0101;
`endif
                end else if (e <= -12'sd151) begin
                    z_nxt = {s, 31'b0};
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                    flg_nxt = 4'b0011;
`endif
                end else begin
                    state_nxt = DENORMALISE;
                end
            end
            DENORMALISE: begin
                if (e < -12'sd126) begin
                    z_m_nxt       = {1'b0, z_m[23:1]};
                    guard_nxt     = z_m[0];
                    round_bit_nxt = guard;
                    sticky_nxt    = sticky | round_bit;
                    e_nxt         = e + 12'sd1;
                end else begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (guard && (round_bit || sticky || z_m[0])) begin
                    if (z_m == 24'hFFFFFF) begin
                        z_m_nxt = 24'h800000;
                        e_nxt   = e + 12'sd1;
                    end else begin
                        z_m_nxt = z_m + 24'd1;
                    end
                end
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                inexact_nxt = guard | round_bit | sticky;
`endif
                state_nxt = PACK;
            end
            PACK: begin
                if (e > 12'sd127) begin
                    z_nxt = {s, 8'hFF, 23'b0};
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                    flg_nxt = 4'b0101;
`endif
                end else if (e == -12'sd126 && !z_m[23]) begin
                    z_nxt = {s, 8'h00, z_m[22:0]};
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                    flg_nxt = {2'b00, inexact_q, inexact_q};
`endif
                end else begin
                    z_nxt = {s, exp8, z_m[22:0]};
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                    flg_nxt = {3'b000, inexact_q};
`endif
                end
                state_nxt = PUT_Z;
            end
            PUT_Z: begin
                stb_nxt = 1'b1;
                out_nxt = z;
`ifdef DOUBLE_TO_FLOAT_FLAGS_EN
                flags_nxt = flg;
`endif
                if (stb_q && io.output_z_ack) begin
                    stb_nxt   = 1'b0;
                    state_nxt = GET_A;
                end
            end
            default: state_nxt = GET_A;
        endcase
    end

endmodule
